// File: rtl/rf_access_sequencer_if.sv
// ============================================================================
// Module      : rf_access_sequencer_if
// Description : Handshake and register-file control bundle for
//               rf_access_sequencer.
//               master : sample source / controlling side (drives start,
//                        stop, in_valid; observes everything else)
//               slave  : the sequencer itself
//               Signals: start, stop, in_valid, in_ready, wr_en, wr_addr,
//                        rd_en, rd_addr1..3, out_valid, busy, done and,
//                        when SAMPLE_COUNT_EN is defined, sample_count[15:0].
// Macro       : SAMPLE_COUNT_EN adds the sample_count signal.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rf_access_sequencer_if #(
  parameter int AW = 4
);
  logic          start;
  logic          stop;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [AW-1:0] rd_addr3;
  logic          out_valid;
  logic          busy;
  logic          done;
`ifdef SAMPLE_COUNT_EN
  logic [15:0]   sample_count;
`endif

  modport master (
    output start, stop, in_valid,
    input  in_ready, wr_en, wr_addr, rd_en, rd_addr1, rd_addr2, rd_addr3,
           out_valid, busy, done
`ifdef SAMPLE_COUNT_EN
    , input sample_count
`endif
  );

  modport slave (
    input  start, stop, in_valid,
    output in_ready, wr_en, wr_addr, rd_en, rd_addr1, rd_addr2, rd_addr3,
           out_valid, busy, done
`ifdef SAMPLE_COUNT_EN
    , output sample_count
`endif
  );
endinterface

`default_nettype wire

// File: rtl/rf_access_sequencer.sv
// ============================================================================
// Module      : rf_access_sequencer
// Description : Handshaked address sequencer for a DEPTH-entry sample
//               register file (one write port, three history read ports).
//               Every accepted sample produces a registered write strobe;
//               once three samples of history exist, each accepted sample
//               also produces a read strobe with the addresses of the
//               samples 1, 2 and 3 back. out_valid is the read strobe
//               delayed by LAT cycles.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               bus        - rf_access_sequencer_if.slave (start/stop pulses,
//                            in_valid/in_ready handshake, wr_en/wr_addr,
//                            rd_en/rd_addr1..3, out_valid, busy, done)
// Macro       : SAMPLE_COUNT_EN adds a 16-bit saturating per-run count of
//               accepted samples (bus.sample_count).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_access_sequencer #(
  parameter int DEPTH = 15,  // register-file entries, addresses wrap mod DEPTH
  parameter int AW    = 4,   // address width, 2**AW >= DEPTH
  parameter int LAT   = 2    // rd_en to read-data-valid latency, 1..4
) (
  input wire logic             clk,
  input wire logic             rst_n,
  rf_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Pipe stages below LAT-2 still have more than one cycle to travel when
  // the FSM leaves DRAIN; anything in them must be allowed to emerge first.
  // Stage LAT-2 emerges in the done cycle itself, so it never blocks.
  localparam int             c_HOLD_BITS = (LAT > 2) ? LAT - 2 : 0;
  localparam logic [LAT-1:0] c_HOLD_MASK = LAT'((1 << c_HOLD_BITS) - 1);
  localparam logic [AW-1:0]  c_LAST      = AW'(DEPTH - 1);

  state_t         r_state;
  logic [AW-1:0]  r_wr_ptr;
  logic [1:0]     r_fill_cnt;
  logic [LAT-1:0] r_vpipe;
  logic           r_wr_en;
  logic [AW-1:0]  r_wr_addr;
  logic           r_rd_en;
  logic [AW-1:0]  r_rd_addr1;
  logic [AW-1:0]  r_rd_addr2;
  logic [AW-1:0]  r_rd_addr3;
  logic           r_busy;
  logic           r_done;
`ifdef SAMPLE_COUNT_EN
  logic [15:0]    r_sample_count;
`endif

  logic           w_in_ready;
  logic           w_accept;
  logic           w_drain_ok;

  // (ptr - n) mod DEPTH, computed as ptr + (DEPTH - n) in AW+1 bits with a
  // single conditional subtract so no out-of-range address can appear.
  function automatic logic [AW-1:0] f_back(input logic [AW-1:0] ptr,
                                           input int unsigned   n);
    logic [AW:0] sum;
    sum = {1'b0, ptr} + (AW+1)'(DEPTH - n);
    if (sum >= (AW+1)'(DEPTH)) begin
      sum = sum - (AW+1)'(DEPTH);
    end
    return AW'(sum);
  endfunction

  // stop has priority over a coincident sample.
  assign w_in_ready = ((r_state == S_FILL) || (r_state == S_RUN)) && !bus.stop;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_drain_ok = !r_rd_en && ((r_vpipe & c_HOLD_MASK) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_fill_cnt     <= '0;
      r_vpipe        <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_rd_en        <= 1'b0;
      r_rd_addr1     <= '0;
      r_rd_addr2     <= '0;
      r_rd_addr3     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
`ifdef SAMPLE_COUNT_EN
      r_sample_count <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      r_vpipe <= (r_vpipe << 1) | LAT'(r_rd_en);

      if (w_accept) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_wr_ptr;
        r_wr_ptr  <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
        if (r_state == S_RUN) begin
          r_rd_en    <= 1'b1;
          r_rd_addr1 <= f_back(r_wr_ptr, 1);
          r_rd_addr2 <= f_back(r_wr_ptr, 2);
          r_rd_addr3 <= f_back(r_wr_ptr, 3);
        end else if (r_fill_cnt != 2'd3) begin
          r_fill_cnt <= r_fill_cnt + 2'd1;
        end
`ifdef SAMPLE_COUNT_EN
        if (r_sample_count != 16'hFFFF) begin
          r_sample_count <= r_sample_count + 16'd1;
        end
`endif
      end

      case (r_state)
        S_IDLE: begin
          r_wr_ptr   <= '0;
          r_fill_cnt <= '0;
          // busy drops here, one cycle after the done cycle, unless a new
          // run starts straight away.
          r_busy     <= bus.start;
          if (bus.start) begin
            r_state        <= S_FILL;
`ifdef SAMPLE_COUNT_EN
            r_sample_count <= '0;
`endif
          end
        end
        S_FILL: begin
          if (bus.stop) begin
            r_state <= S_DRAIN;
          end else if (w_accept && (r_fill_cnt == 2'd2)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // busy is left high so it also covers the done cycle.
          if (w_drain_ok) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.rd_en        = r_rd_en;
  assign bus.rd_addr1     = r_rd_addr1;
  assign bus.rd_addr2     = r_rd_addr2;
  assign bus.rd_addr3     = r_rd_addr3;
  assign bus.out_valid    = r_vpipe[LAT-1];
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
`ifdef SAMPLE_COUNT_EN
  assign bus.sample_count = r_sample_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_access_sequencer.sv
// ============================================================================
// Module      : tb_rf_access_sequencer
// Description : Self-checking bench for rf_access_sequencer. A cycle-level
//               reference model derived from run-level rules (count of
//               accepted samples, history of read strobes by cycle) predicts
//               every output; scenario tasks add directed checks.
// Macro       : SAMPLE_COUNT_EN also checks sample_count.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_access_sequencer;

  localparam int DEPTH = 15;
  localparam int AW    = 4;
  localparam int LAT   = 2;

`ifdef SAMPLE_COUNT_EN
  localparam int VW = 38;
`else
  localparam int VW = 22;
`endif
  typedef logic [VW-1:0] vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rf_access_sequencer_if #(.AW(AW)) bus_if ();

  rf_access_sequencer #(.DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_active, m_drain, m_wr_en, m_rd_en, m_done, m_out_valid;
  int m_nacc, m_cyc, m_last_rd, m_done_at, m_sc;
  int m_wr_addr, m_rd1, m_rd2, m_rd3;
  bit m_rd_log [64];

  task automatic model_reset();
    m_active = 0; m_drain = 0; m_wr_en = 0; m_rd_en = 0; m_done = 0;
    m_out_valid = 0; m_nacc = 0; m_last_rd = -100; m_done_at = 0; m_sc = 0;
    m_wr_addr = 0; m_rd1 = 0; m_rd2 = 0; m_rd3 = 0;
    foreach (m_rd_log[i]) m_rd_log[i] = 0;
  endtask

  // Advance the model across one rising edge using the inputs the DUT saw.
  task automatic model_step();
    bit ready, acc;
    ready = m_active && !m_drain && !bus_if.stop;
    acc   = bus_if.in_valid && ready;
    m_cyc++;
    m_wr_en = acc;
    m_rd_en = acc && (m_nacc >= 3);
    m_done  = 0;
    if (acc) begin
      m_wr_addr = m_nacc % DEPTH;
      if (m_rd_en) begin
        m_rd1 = (m_nacc - 1) % DEPTH;
        m_rd2 = (m_nacc - 2) % DEPTH;
        m_rd3 = (m_nacc - 3) % DEPTH;
        m_last_rd = m_cyc;
      end
      m_nacc++;
      if (m_sc < 65535) m_sc++;
    end
    m_rd_log[m_cyc % 64] = m_rd_en;
    m_out_valid = m_rd_log[(m_cyc - LAT) % 64];
    if (m_active && !m_drain && bus_if.stop) begin
      m_drain   = 1;
      m_done_at = (m_cyc + 1 > m_last_rd + LAT) ? m_cyc + 1 : m_last_rd + LAT;
    end else if (!m_active && bus_if.start) begin
      m_active = 1; m_drain = 0; m_nacc = 0; m_sc = 0; m_last_rd = -100;
    end
    if (m_active && m_drain && (m_cyc == m_done_at)) begin
      m_done   = 1;
      m_active = 0;
    end
  endtask

  function automatic vec_t obs();
    vec_t v;
    v = '0;
    v[21:0] = {bus_if.in_ready, bus_if.wr_en, bus_if.wr_addr, bus_if.rd_en,
               bus_if.rd_addr1, bus_if.rd_addr2, bus_if.rd_addr3,
               bus_if.out_valid, bus_if.busy, bus_if.done};
`ifdef SAMPLE_COUNT_EN
    v[37:22] = bus_if.sample_count;
`endif
    return v;
  endfunction

  function automatic vec_t expv();
    vec_t v;
    v = '0;
    v[21:0] = {(m_active && !m_drain && !bus_if.stop), m_wr_en, 4'(m_wr_addr),
               m_rd_en, 4'(m_rd1), 4'(m_rd2), 4'(m_rd3),
               m_out_valid, (m_active || m_done), m_done};
`ifdef SAMPLE_COUNT_EN
    v[37:22] = 16'(m_sc);
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_in(input bit s_start, input bit s_stop, input bit s_valid);
    bus_if.start    = s_start;
    bus_if.stop     = s_stop;
    bus_if.in_valid = s_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0);
    model_reset();
    m_cyc = 1000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(0, (i == 1), 1);   // in_ready must stay low in IDLE
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL reset_idle c%0d: got %h want %h", i, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_fill_run();
    int wq[$];
    logic [11:0] rq[$];
    for (int i = 0; i < 14; i++) begin
      set_in((i == 0), (i == 9), (i <= 5));  // start+in_valid at i=0: no accept
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL fill_run c%0d: got %h want %h", i, obs(), expv());
      end
      if (bus_if.wr_en) wq.push_back(int'(bus_if.wr_addr));
      if (bus_if.rd_en) rq.push_back({bus_if.rd_addr1, bus_if.rd_addr2, bus_if.rd_addr3});
      tick();
    end
    checks++;
    if (wq != '{0, 1, 2, 3, 4}) begin
      errors++; $display("FAIL fill_run_wr_seq: got %p want 0,1,2,3,4", wq);
    end
    checks++;
    if (rq != '{12'h210, 12'h321}) begin
      errors++; $display("FAIL fill_run_rd_seq: got %p want 210,321", rq);
    end
  endtask

  task automatic test_wrap();
    int zeros, ones;
    zeros = 0; ones = 0;
    for (int i = 0; i < 24; i++) begin
      set_in((i == 0), (i == 18), (i >= 1 && i <= 17));
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL wrap c%0d: got %h want %h", i, obs(), expv());
      end
      if (bus_if.wr_en && bus_if.wr_addr == 4'd0) begin
        zeros++;
        if (zeros == 2) begin
          checks++;
          if ({bus_if.rd_addr1, bus_if.rd_addr2, bus_if.rd_addr3} !== {4'd14, 4'd13, 4'd12}) begin
            errors++; $display("FAIL wrap_at0: got %h want ed c", {bus_if.rd_addr1, bus_if.rd_addr2, bus_if.rd_addr3});
          end
        end
      end
      if (bus_if.wr_en && bus_if.wr_addr == 4'd1) begin
        ones++;
        if (ones == 2) begin
          checks++;
          if ({bus_if.rd_addr1, bus_if.rd_addr2, bus_if.rd_addr3} !== {4'd0, 4'd14, 4'd13}) begin
            errors++; $display("FAIL wrap_at1: got %h want 0ed", {bus_if.rd_addr1, bus_if.rd_addr2, bus_if.rd_addr3});
          end
        end
      end
      tick();
    end
    checks++;
    if (zeros != 2 || ones != 2) begin
      errors++; $display("FAIL wrap_seen: got zeros=%0d ones=%0d want 2 2", zeros, ones);
    end
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 40; i++) begin
      bit v;
      if (i <= 3)       v = (i >= 1);
      else if (i < 12)  v = (i % 2 == 0);   // 1,0,1,0 in RUN
      else              v = 1'($urandom_range(0, 1));
      set_in((i == 0), (i == 33), v);
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL bubbles c%0d: got %h want %h", i, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_stop_run();
    int last_rd, done_i, done_cnt;
    last_rd = -1; done_i = -1; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      set_in((i == 0), (i == 6), (i >= 1 && i <= 6));
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL stop_run c%0d: got %h want %h", i, obs(), expv());
      end
      if (i == 6) begin
        checks++;
        if (bus_if.in_ready !== 1'b0) begin
          errors++; $display("FAIL stop_run_ready: got %b want 0", bus_if.in_ready);
        end
      end
      if (bus_if.rd_en) last_rd = i;
      if (bus_if.done) begin done_cnt++; done_i = i; end
      tick();
    end
    checks++;
    if (done_cnt != 1 || done_i - last_rd != LAT) begin
      errors++; $display("FAIL stop_run_done: got cnt=%0d gap=%0d want 1 %0d", done_cnt, done_i - last_rd, LAT);
    end
    for (int j = 0; j < 7; j++) begin
      set_in((j == 0), (j == 3), (j == 1));
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL restart c%0d: got %h want %h", j, obs(), expv());
      end
      if (j == 2) begin
        checks++;
        if (!(bus_if.wr_en === 1'b1 && bus_if.wr_addr === 4'd0)) begin
          errors++; $display("FAIL restart_addr: got en=%b addr=%0d want 1 0", bus_if.wr_en, bus_if.wr_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_stop_fill();
    int rd_seen, done_cnt;
    rd_seen = 0; done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      set_in((i == 0 || i == 4), (i == 3), (i >= 1 && i <= 3));
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL stop_fill c%0d: got %h want %h", i, obs(), expv());
      end
      if (bus_if.rd_en || bus_if.out_valid) rd_seen++;
      if (bus_if.done) begin
        done_cnt++;
        checks++;
        if (i != 5) begin
          errors++; $display("FAIL stop_fill_done_at: got c%0d want c5", i);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus_if.busy !== 1'b0) begin
          errors++; $display("FAIL stop_fill_busy: got %b want 0", bus_if.busy);
        end
      end
      tick();
    end
    checks++;
    if (rd_seen != 0 || done_cnt != 1) begin
      errors++; $display("FAIL stop_fill_summary: got rd=%0d done=%0d want 0 1", rd_seen, done_cnt);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      set_in((i == 0), 0, (i >= 1));
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL areset_pre c%0d: got %h want %h", i, obs(), expv());
      end
      tick();
    end
    set_in(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL areset_immediate: got %h want 0", obs());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL areset_hold: got %h want 0", obs());
    end
    rst_n = 1'b1;
    model_reset();
    for (int j = 0; j < 8; j++) begin
      set_in((j == 0), (j == 4), (j == 1 || j == 2));
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL areset_post c%0d: got %h want %h", j, obs(), expv());
      end
      if (j == 2) begin
        checks++;
        if (!(bus_if.wr_en === 1'b1 && bus_if.wr_addr === 4'd0)) begin
          errors++; $display("FAIL areset_addr: got en=%b addr=%0d want 1 0", bus_if.wr_en, bus_if.wr_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 1)));
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random c%0d: got %h want %h", i, obs(), expv());
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, (i == 0), 0);
      #1;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random_drain c%0d: got %h want %h", i, obs(), expv());
      end
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill_run();
    test_wrap();
    test_bubbles();
    test_stop_run();
    test_stop_fill();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
